// File: rtl/wb_commit.sv
// Writeback commit stage: GPR file with same-cycle bypass, HI/LO, LLbit
// and a running count of committed GPR writes.
module wb_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_waddr,
    input  logic        wb_we,
    input  logic [31:0] wb_wdata,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    input  logic        flush,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        LLbit_o,
    output logic [31:0] commit_cnt
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        llbit_q, llbit_d;
    logic [31:0] cnt_q, cnt_d;
    logic        gpr_wr;

    assign gpr_wr = wb_we && (wb_waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        llbit_d = llbit_q;
        cnt_d   = cnt_q;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'd0;
            end
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            llbit_d = 1'b0;
            cnt_d   = 32'd0;
        end else begin
            if (gpr_wr) begin
                regs_d[wb_waddr] = wb_wdata;
                cnt_d            = cnt_q + 32'd1;
            end
            if (wb_whilo) begin
                hi_d = wb_hi;
                lo_d = wb_lo;
            end
            // flush only kills a pending LL reservation
            if (flush) begin
                llbit_d = 1'b0;
            end else if (wb_LLbit_we) begin
                llbit_d = wb_LLbit_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q  <= regs_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
        llbit_q <= llbit_d;
        cnt_q   <= cnt_d;
    end

    function automatic logic [31:0] rd_port(
        input logic        re,
        input logic [4:0]  addr
    );
        logic [31:0] v;
        v = 32'd0;
        if (rst || addr == 5'd0) begin
            v = 32'd0;
        end else if (re && wb_we && addr == wb_waddr) begin
            v = wb_wdata;
        end else if (re) begin
            v = regs_q[addr];
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = rd_port(re1, raddr1);
        rdata2 = rd_port(re2, raddr2);
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign LLbit_o    = llbit_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;
    logic [31:0] commit_cnt;

    wb_commit dut (
        .clk(clk), .rst(rst),
        .wb_waddr(wb_waddr), .wb_we(wb_we), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .flush(flush), .re1(re1), .re2(re2),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o),
        .commit_cnt(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    localparam int S_RD1 = 0;
    localparam int S_RD2 = 1;
    localparam int S_HI  = 2;
    localparam int S_LO  = 3;
    localparam int S_LL  = 4;
    localparam int S_CNT = 5;

    item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic exp_v(input string n, input int sel, input logic [31:0] v);
        item_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = v;
        sb.push_back(it);
    endtask

    // Monitor: outputs are stable mid-cycle, compare everything queued
    always @(negedge clk) begin
        item_t it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.sel)
                S_RD1:   act = rdata1;
                S_RD2:   act = rdata2;
                S_HI:    act = hi_o;
                S_LO:    act = lo_o;
                S_LL:    act = {31'd0, LLbit_o};
                default: act = commit_cnt;
            endcase
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h",
                         it.name, act, it.exp);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wb_we       = 1'b0;
        wb_whilo    = 1'b0;
        wb_LLbit_we = 1'b0;
        flush       = 1'b0;
        re1         = 1'b0;
        re2         = 1'b0;
    endtask

    task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_waddr = '0; wb_we = 1'b0; wb_wdata = '0;
        wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;

        // C0: in reset, read port forced to 0 even with a write bypass
        next_cycle();
        rst = 1'b1;
        gpr_write(5'd5, 32'hCAFE_0000);
        re1 = 1'b1; raddr1 = 5'd5;
        exp_v("rst_rdata1", S_RD1, 32'h0);

        // C1: reset state, then write $5
        next_cycle();
        rst = 1'b0;
        exp_v("rst_hi", S_HI, 32'h0);
        exp_v("rst_lo", S_LO, 32'h0);
        exp_v("rst_ll", S_LL, 32'h0);
        exp_v("rst_cnt", S_CNT, 32'h0);
        gpr_write(5'd5, 32'hDEAD_BEEF);

        // C2: read back $5
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd5;
        exp_v("rd_r5", S_RD1, 32'hDEAD_BEEF);
        exp_v("cnt_after_r5", S_CNT, 32'd1);

        // C3: same-cycle bypass on both ports
        next_cycle();
        gpr_write(5'd7, 32'h1234_5678);
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd7;
        exp_v("byp_rd1", S_RD1, 32'h1234_5678);
        exp_v("byp_rd2", S_RD2, 32'h1234_5678);
        exp_v("cnt_pre_edge", S_CNT, 32'd1);

        // C4: disabled port reads 0, stored value visible on other port
        next_cycle();
        re2 = 1'b0; raddr2 = 5'd7;
        re1 = 1'b1; raddr1 = 5'd7;
        exp_v("re2_off", S_RD2, 32'h0);
        exp_v("rd_r7", S_RD1, 32'h1234_5678);
        exp_v("cnt_2", S_CNT, 32'd2);

        // C5: write to $0 is dropped and reads 0 even as bypass
        next_cycle();
        gpr_write(5'd0, 32'hFFFF_FFFF);
        re1 = 1'b1; raddr1 = 5'd0;
        exp_v("r0_byp", S_RD1, 32'h0);

        // C6
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd0;
        exp_v("r0_rd", S_RD1, 32'h0);
        exp_v("cnt_r0_nocount", S_CNT, 32'd2);

        // C7: flush beats LL write, GPR write unaffected by flush
        next_cycle();
        flush = 1'b1;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        gpr_write(5'd9, 32'h0000_00A5);

        // C8
        next_cycle();
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        re2 = 1'b1; raddr2 = 5'd9;
        exp_v("ll_flush", S_LL, 32'h0);
        exp_v("flush_gpr", S_RD2, 32'h0000_00A5);
        exp_v("flush_cnt", S_CNT, 32'd3);

        // C9: HI/LO and GPR in the same cycle
        next_cycle();
        exp_v("ll_set", S_LL, 32'h1);
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        gpr_write(5'd3, 32'h0000_0033);

        // C10
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd3;
        exp_v("hi_wr", S_HI, 32'h1);
        exp_v("lo_wr", S_LO, 32'h2);
        exp_v("rd_r3", S_RD1, 32'h0000_0033);
        exp_v("cnt_4", S_CNT, 32'd4);

        // C11: mid-stream reset with writes in flight
        next_cycle();
        rst = 1'b1;
        gpr_write(5'd4, 32'h0000_0044);
        wb_whilo = 1'b1; wb_hi = 32'h9; wb_lo = 32'h9;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        re1 = 1'b1; raddr1 = 5'd3;
        exp_v("rst_rd_forced", S_RD1, 32'h0);
        exp_v("hi_pre_rst", S_HI, 32'h1);

        // C12
        next_cycle();
        rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd4;
        exp_v("r3_cleared", S_RD1, 32'h0);
        exp_v("r4_discard", S_RD2, 32'h0);
        exp_v("hi_cleared", S_HI, 32'h0);
        exp_v("lo_cleared", S_LO, 32'h0);
        exp_v("ll_cleared", S_LL, 32'h0);
        exp_v("cnt_cleared", S_CNT, 32'h0);
        gpr_write(5'd6, 32'h0000_0066);

        // C13
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd6;
        exp_v("rd_r6", S_RD1, 32'h0000_0066);
        exp_v("cnt_post_rst", S_CNT, 32'd1);

        // C14: preload the counter to its maximum and commit once more
        next_cycle();
        dut.cnt_q = 32'hFFFF_FFFF;
        gpr_write(5'd8, 32'h0000_0088);

        // C15
        next_cycle();
        re2 = 1'b1; raddr2 = 5'd8;
        exp_v("cnt_wrap", S_CNT, 32'h0);
        exp_v("rd_r8", S_RD2, 32'h0000_0088);
        gpr_write(5'd10, 32'h0000_0010);

        // C16
        next_cycle();
        exp_v("cnt_after_wrap", S_CNT, 32'd1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
